// File: rtl/reg_read.sv
// Integer (x) and floating-point (f) register banks with a registered two-operand read port.
// Define REG_READ_BYPASS_EN for write-first forwarding of same-edge writes; default is read-first.
module reg_read #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enabled,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic [$clog2(NREG)-1:0] rs2,
  input  logic                    rs1_is_f,
  input  logic                    rs2_is_f,
  input  logic                    reg_w_enable,
  input  logic                    freg_w_enable,
  input  logic [$clog2(NREG)-1:0] reg_w_dest,
  input  logic [XLEN-1:0]         reg_w_data,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data,
  output logic                    completed
);

  localparam int AW = $clog2(NREG);

  typedef enum logic {
    ST_IDLE,
    ST_READ
  } state_t;

  logic [XLEN-1:0] x_reg [NREG];
  logic [XLEN-1:0] f_reg [NREG];
  logic [XLEN-1:0] rs1_next;
  logic [XLEN-1:0] rs2_next;
  logic            done_reg;
  logic            done_next;
  state_t          state;

  // Banks are plain flops: every entry must clear on the asynchronous reset.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bank
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          f_reg[gi] <= '0;
        end else if (freg_w_enable && (reg_w_dest == AW'(gi))) begin
          f_reg[gi] <= reg_w_data;
        end
      end

      if (gi == 0) begin : g_x0
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            x_reg[gi] <= '0;
          end else begin
            x_reg[gi] <= '0;
          end
        end
      end else begin : g_xn
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            x_reg[gi] <= '0;
          end else if (reg_w_enable && (reg_w_dest == AW'(gi))) begin
            x_reg[gi] <= reg_w_data;
          end
        end
      end
    end
  endgenerate

  function automatic logic [XLEN-1:0] pick(input logic [AW-1:0] idx, input logic is_f);
    logic [XLEN-1:0] val;
    if (is_f) begin
      val = f_reg[idx];
`ifdef REG_READ_BYPASS_EN
      if (freg_w_enable && (reg_w_dest == idx)) val = reg_w_data;
`endif
    end else begin
      val = x_reg[idx];
`ifdef REG_READ_BYPASS_EN
      if (reg_w_enable && (reg_w_dest == idx)) val = reg_w_data;
`endif
      // x0 reads zero even when a same-edge write targets it
      if (idx == '0) val = '0;
    end
    return val;
  endfunction

  always_comb begin
    rs1_next = pick(rs1, rs1_is_f);
    rs2_next = pick(rs2, rs2_is_f);
  end

  always_comb begin
    state     = ST_IDLE;
    done_next = done_reg;
    completed = 1'b0;
    if (enabled) state = ST_READ;
    case (state)
      ST_IDLE: completed = done_reg;
      ST_READ: begin
        done_next = 1'b1;
        completed = 1'b0;
      end
      default: completed = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_reg <= 1'b0;
      rs1_data <= '0;
      rs2_data <= '0;
    end else begin
      done_reg <= done_next;
      if (enabled) begin
        rs1_data <= rs1_next;
        rs2_data <= rs2_next;
      end
    end
  end

endmodule

// File: tb/tb_reg_read.sv
// Scoreboard bench for reg_read: stimulus queues expected operands, a negedge monitor
// compares them on each rising edge of completed.
module tb_reg_read;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        rs1_is_f = 1'b0;
  logic        rs2_is_f = 1'b0;
  logic        reg_w_enable = 1'b0;
  logic        freg_w_enable = 1'b0;
  logic [4:0]  reg_w_dest = '0;
  logic [31:0] reg_w_data = '0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        completed;

  int checks = 0;
  int failures = 0;
  int txn = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_x7;

  always #5 clk = ~clk;

  reg_read #(.XLEN(32), .NREG(32)) dut (
    .clk(clk),
    .rstn(rstn),
    .enabled(enabled),
    .rs1(rs1),
    .rs2(rs2),
    .rs1_is_f(rs1_is_f),
    .rs2_is_f(rs2_is_f),
    .reg_w_enable(reg_w_enable),
    .freg_w_enable(freg_w_enable),
    .reg_w_dest(reg_w_dest),
    .reg_w_data(reg_w_data),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .completed(completed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic xe, input logic fe, input logic [4:0] dest, input logic [31:0] data);
    reg_w_enable  = xe;
    freg_w_enable = fe;
    reg_w_dest    = dest;
    reg_w_data    = data;
    @(posedge clk); #1;
    reg_w_enable  = 1'b0;
    freg_w_enable = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic fa, input logic [4:0] b, input logic fb,
                    input logic [31:0] e1, input logic [31:0] e2);
    enabled  = 1'b1;
    rs1      = a;
    rs1_is_f = fa;
    rs2      = b;
    rs2_is_f = fb;
    exp_q.push_back({e1, e2});
    @(posedge clk); #1;
    reg_w_enable  = 1'b0;
    freg_w_enable = 1'b0;
    check("completed_during_req", {31'b0, completed}, 32'd0);
    enabled = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: one transaction per rising edge of completed
  initial begin
    logic        comp_prev;
    logic [63:0] e;
    comp_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && completed && !comp_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion: got completed=1 expected no pending request");
        end else begin
          e = exp_q.pop_front();
          check("rs1_data", rs1_data, e[63:32]);
          check("rs2_data", rs2_data, e[31:0]);
          $display("txn %0d rs1_data=%h (exp %h) rs2_data=%h (exp %h)",
                   txn, rs1_data, e[63:32], rs2_data, e[31:0]);
          txn++;
        end
      end
      comp_prev = completed;
    end
  end

  initial begin
`ifdef REG_READ_BYPASS_EN
    exp_x7 = 32'h12345678;
`else
    exp_x7 = 32'h0BAD0007;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_rs1_data", rs1_data, 32'd0);
    check("reset_rs2_data", rs2_data, 32'd0);
    check("reset_completed", {31'b0, completed}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("completed_before_first", {31'b0, completed}, 32'd0);

    rd(5'd5, 1'b0, 5'd5, 1'b1, 32'd0, 32'd0);
    check("completed_after_first", {31'b0, completed}, 32'd1);

    wr(1'b1, 1'b0, 5'd3, 32'hDEADBEEF);
    rd(5'd3, 1'b0, 5'd3, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);

    // x0 discards writes; f0 keeps them
    wr(1'b1, 1'b0, 5'd0, 32'h00000001);
    wr(1'b1, 1'b1, 5'd0, 32'h3F800000);
    rd(5'd0, 1'b0, 5'd0, 1'b1, 32'd0, 32'h3F800000);

    // same-edge write and read of x7
    wr(1'b1, 1'b0, 5'd7, 32'h0BAD0007);
    reg_w_enable = 1'b1;
    reg_w_dest   = 5'd7;
    reg_w_data   = 32'h12345678;
    rd(5'd7, 1'b0, 5'd3, 1'b0, exp_x7, 32'hDEADBEEF);
    rd(5'd7, 1'b0, 5'd7, 1'b0, 32'h12345678, 32'h12345678);

    // outputs hold while idle even as writes continue
    wr(1'b1, 1'b1, 5'd7, 32'h55555555);
    repeat (2) @(posedge clk);
    #1;
    check("hold_rs1_data", rs1_data, 32'h12345678);
    check("hold_rs2_data", rs2_data, 32'h12345678);

    // asynchronous reset between edges during a request
    enabled  = 1'b1;
    rs1      = 5'd3;
    rs1_is_f = 1'b0;
    rs2      = 5'd0;
    rs2_is_f = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_rs1_data", rs1_data, 32'hDEADBEEF);
    #1;
    rstn = 1'b0;
    #1;
    check("async_reset_rs1_data", rs1_data, 32'd0);
    check("async_reset_completed", {31'b0, completed}, 32'd0);
    enabled = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    check("post_reset_completed", {31'b0, completed}, 32'd0);
    rd(5'd3, 1'b0, 5'd0, 1'b1, 32'd0, 32'd0);

    // back-to-back reads of f1, f2, f4
    wr(1'b0, 1'b1, 5'd1, 32'd1);
    wr(1'b0, 1'b1, 5'd2, 32'd2);
    wr(1'b0, 1'b1, 5'd4, 32'd4);
    enabled  = 1'b1;
    rs1_is_f = 1'b1;
    rs2_is_f = 1'b1;
    rs2      = 5'd1;
    rs1      = 5'd1;
    @(posedge clk); #1;
    check("b2b_completed_0", {31'b0, completed}, 32'd0);
    rs1 = 5'd2;
    @(posedge clk); #1;
    check("b2b_completed_1", {31'b0, completed}, 32'd0);
    rs1 = 5'd4;
    exp_q.push_back({32'd4, 32'd1});
    @(posedge clk); #1;
    check("b2b_completed_2", {31'b0, completed}, 32'd0);
    enabled = 1'b0;
    #1;
    check("b2b_final_rs1_data", rs1_data, 32'd4);
    check("b2b_final_completed", {31'b0, completed}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_requests: got %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
